mdu_seq: RTL

Iterative multiply/divide sequencer for the SCPU. It owns the HI/LO register pair and the shift-add/shift-subtract datapath, so MULT/MULTU (and, when compiled in, DIV/DIVU) run over 32 cycles instead of through a combinational array. The SCPU stalls on `busy` whenever it issues an MDU op or reads HI/LO. The block sits beside the ALU in the execute stage and does not connect to Memory or the MIO bus.

---
 rtl/mdu_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32-cycle multiply/divide sequencer owning the HI/LO pair.
// Ports: clk, reset (sync, active-high); start/op/rs_data/rt_data issue an op;
//   busy (op in flight), done (1-cycle pulse after HI/LO update), hi, lo.
// Build option: define MDU_DIV_EN to include DIV/DIVU; otherwise they are no-ops.
module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] opa;        // multiplicand / dividend magnitude (dividend shifts out MSB first)
  logic [31:0] opb;        // multiplier magnitude (shifts out LSB first) / divisor magnitude
  logic [63:0] acc;        // mult: running product; div: {remainder, quotient}
  logic        prod_neg;   // negate product or quotient at completion
  logic        is_div;

  logic        sgn_a, sgn_b;
  logic [31:0] mag_a, mag_b;
  logic        issue_mul, issue_div, issue_neg;
  logic [32:0] mul_sum;
  logic [63:0] step_acc;
  logic [63:0] res64;
  logic [31:0] res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic        rem_neg;    // remainder takes the dividend's sign
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    // Unsigned ops (op[0]=1) pass operands through unchanged.
    sgn_a     = ~op[0] & rs_data[31];
    sgn_b     = ~op[0] & rt_data[31];
    mag_a     = sgn_a ? -rs_data : rs_data;
    mag_b     = sgn_b ? -rt_data : rt_data;
    issue_mul = (op[2:1] == 2'b00);
`ifdef MDU_DIV_EN
    issue_div = (op[2:1] == 2'b01);
`else
    issue_div = 1'b0;
`endif
    // Divide by zero must leave LO all-ones regardless of dividend sign.
    issue_neg = (sgn_a ^ sgn_b) & ~(issue_div && (rt_data == 32'd0));

    // Shift-add: add multiplicand into upper half, then shift whole product right.
    mul_sum  = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
    step_acc = {mul_sum, acc[31:1]};

`ifdef MDU_DIV_EN
    // Restoring divide: bring in next dividend bit, subtract if it fits.
    // When rem_ge holds the difference is below the divisor, so 32 bits suffice.
    rem_sh  = {acc[63:32], opa[31]};
    rem_ge  = (rem_sh >= {1'b0, opb});
    rem_sub = rem_sh[31:0] - opb;
    if (is_div)
      step_acc = rem_ge ? {rem_sub, acc[30:0], 1'b1}
                        : {rem_sh[31:0], acc[30:0], 1'b0};
`endif

    res64  = prod_neg ? -step_acc : step_acc;
    res_hi = res64[63:32];
    res_lo = res64[31:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      res_lo = prod_neg ? -step_acc[31:0]  : step_acc[31:0];
      res_hi = rem_neg  ? -step_acc[63:32] : step_acc[63:32];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc      <= 64'd0;
      opa      <= 32'd0;
      opb      <= 32'd0;
      prod_neg <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      rem_neg  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (issue_mul || issue_div) begin
              opa      <= mag_a;
              opb      <= mag_b;
              acc      <= 64'd0;
              prod_neg <= issue_neg;
              cnt      <= 5'd0;
              busy     <= 1'b1;
              state    <= RUN;
`ifdef MDU_DIV_EN
              is_div   <= issue_div;
              rem_neg  <= sgn_a;
`endif
            end else if (op == 3'b100) begin
              hi <= rs_data;
            end else if (op == 3'b101) begin
              lo <= rs_data;
            end
          end
        end
        RUN: begin
          // start is deliberately ignored in this state.
          acc <= step_acc;
          cnt <= cnt + 5'd1;
          if (is_div) opa <= opa << 1;
          else        opb <= opb >> 1;
          if (cnt == 5'd31) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
